// File: rtl/spi_pkg.sv
// spi_pkg: shared types and helpers for the SPI master controller.
package spi_pkg;

  // Controller phases; everything except IDLE counts as busy.
  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    XFER,
    WAIT,
    HOLD
  } spi_state_e;

  // Width of the per-word edge counter (must hold 2*data_w).
  function automatic int edge_cnt_w(input int data_w);
    return $clog2(2 * data_w) + 1;
  endfunction

endpackage

// File: rtl/spi_shift_reg.sv
// spi_shift_reg: transmit and receive shift registers for one SPI word.
// The transmit side presents the bit to put on mosi (o_msb) and drops it
// when i_shift_out is set; a load and a shift in the same cycle shift the
// freshly loaded word. The receive side shifts i_in_bit in at the LSB, and
// o_rx_next shows the value the register takes at the next clock.
module spi_shift_reg
  import spi_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_shift_out,
  input  logic              i_shift_in,
  input  logic              i_in_bit,
  output logic              o_msb,
  output logic [DATA_W-1:0] o_rx_next
);

  logic [DATA_W-1:0] r_tx;
  logic [DATA_W-1:0] r_rx;
  logic [DATA_W-1:0] w_tx_base;

  assign w_tx_base = i_load ? i_data : r_tx;
  assign o_msb     = w_tx_base[DATA_W-1];
  assign o_rx_next = i_shift_in ? {r_rx[DATA_W-2:0], i_in_bit} : r_rx;

  // Load / shift the transmit word and accumulate received bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx <= '0;
      r_rx <= '0;
    end else begin
      if (i_shift_out) begin
        r_tx <= {w_tx_base[DATA_W-2:0], 1'b0};
      end else if (i_load) begin
        r_tx <= w_tx_base;
      end
      r_rx <= o_rx_next;
    end
  end

endmodule

// File: rtl/spi_master_ctrl.sv
// spi_master_ctrl: SPI master transaction sequencer driven by divider ticks.
// Optional macro SPI_MODE_CFG_EN adds cpol/cpha inputs (sampled at the IDLE
// handshake); without it the controller is fixed to mode 0.
module spi_master_ctrl
  import spi_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int CS_SETUP = 1,
  parameter int CS_HOLD  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  input  logic              tx_last,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              busy,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso,
  output logic              cs_n
`ifdef SPI_MODE_CFG_EN
  ,
  input  logic              cpol,
  input  logic              cpha
`endif
);

  localparam int EDGE_W = edge_cnt_w(DATA_W);
  localparam int TMAX   = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
  localparam int TCNT_W = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(2 * DATA_W - 1);
  localparam logic [TCNT_W-1:0] SETUP_END = TCNT_W'(CS_SETUP - 1);
  localparam logic [TCNT_W-1:0] HOLD_END  = TCNT_W'(CS_HOLD - 1);

  spi_state_e        r_state;
  spi_state_e        w_state_next;
  logic [EDGE_W-1:0] r_edge_cnt;
  logic [TCNT_W-1:0] r_tick_cnt;
  logic              r_last;
  logic              r_cpha;
  logic              r_cs_n;
  logic              r_sclk;
  logic              r_mosi;
  logic [DATA_W-1:0] r_rx_data;
  logic              r_rx_valid;
  logic              r_busy;

  logic              w_cpol_in;
  logic              w_cpha_in;
  logic              w_hs;
  logic              w_edge;
  logic              w_odd;
  logic              w_final;
  logic              w_cpha_cur;
  logic              w_drive;
  logic              w_sample;
  logic              w_msb;
  logic [DATA_W-1:0] w_rx_next;

`ifdef SPI_MODE_CFG_EN
  assign w_cpol_in = cpol;
  assign w_cpha_in = cpha;
`else
  assign w_cpol_in = 1'b0;
  assign w_cpha_in = 1'b0;
`endif

  assign tx_ready   = !rst && ((r_state == IDLE) || (r_state == WAIT));
  assign w_hs       = tx_valid && tx_ready;
  assign w_edge     = (r_state == XFER) && tick;
  // Edge number is r_edge_cnt+1, so an even count means an odd edge.
  assign w_odd      = !r_edge_cnt[0];
  assign w_final    = w_edge && (r_edge_cnt == LAST_EDGE);
  // A handshake from IDLE uses the live cpha; a burst word uses the latched one.
  assign w_cpha_cur = (r_state == IDLE) ? w_cpha_in : r_cpha;
  // CPHA=0 puts the MSB out at the handshake; CPHA=1 waits for the first edge.
  assign w_drive    = (w_hs && !w_cpha_cur)
                    || (w_edge && (r_cpha ? w_odd : !w_odd) && !w_final);
  assign w_sample   = w_edge && (r_cpha ? !w_odd : w_odd);

  spi_shift_reg #(.DATA_W(DATA_W)) u_shift (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_hs),
    .i_data     (tx_data),
    .i_shift_out(w_drive),
    .i_shift_in (w_sample),
    .i_in_bit   (miso),
    .o_msb      (w_msb),
    .o_rx_next  (w_rx_next)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode: SETUP/HOLD count ticks, XFER ends on the final edge.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE:  if (w_hs) w_state_next = SETUP;
      SETUP: if (tick && (r_tick_cnt == SETUP_END)) w_state_next = XFER;
      XFER:  if (w_final) w_state_next = r_last ? HOLD : WAIT;
      WAIT:  if (w_hs) w_state_next = XFER;
      HOLD:  if (tick && (r_tick_cnt == HOLD_END)) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Registered outputs, counters and per-word latches.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_edge_cnt <= '0;
      r_tick_cnt <= '0;
      r_last     <= 1'b0;
      r_cpha     <= 1'b0;
      r_cs_n     <= 1'b1;
      r_sclk     <= w_cpol_in;
      r_mosi     <= 1'b0;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      r_cs_n     <= (w_state_next == IDLE);
      r_busy     <= (w_state_next != IDLE);
      if (w_hs) begin
        r_last     <= tx_last;
        r_edge_cnt <= '0;
        r_tick_cnt <= '0;
      end
      if (r_state == IDLE) begin
        r_sclk <= w_cpol_in;
        if (w_hs) r_cpha <= w_cpha_in;
      end
      if (tick && ((r_state == SETUP) || (r_state == HOLD))) begin
        r_tick_cnt <= r_tick_cnt + 1'b1;
      end
      if (w_drive) r_mosi <= w_msb;
      if (w_edge) begin
        r_sclk     <= ~r_sclk;
        r_edge_cnt <= r_edge_cnt + 1'b1;
      end
      if (w_final) begin
        r_rx_data  <= w_rx_next;
        r_rx_valid <= 1'b1;
        r_tick_cnt <= '0;
      end
    end
  end

  assign cs_n     = r_cs_n;
  assign sclk     = r_sclk;
  assign mosi     = r_mosi;
  assign rx_data  = r_rx_data;
  assign rx_valid = r_rx_valid;
  assign busy     = r_busy;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// tb_spi_master_ctrl: scoreboard bench for spi_master_ctrl, miso looped to mosi.
module tb_spi_master_ctrl;

  localparam int DATA_W   = 8;
  localparam int CS_SETUP = 1;
  localparam int CS_HOLD  = 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              tick = 1'b0;
  logic [DATA_W-1:0] tx_data = '0;
  logic              tx_valid = 1'b0;
  logic              tx_last = 1'b0;
  logic              tx_ready;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              busy;
  logic              sclk;
  logic              mosi;
  logic              miso;
  logic              cs_n;
  logic              tb_cpol = 1'b0;
`ifdef SPI_MODE_CFG_EN
  logic              tb_cpha = 1'b0;
`endif

  assign miso = mosi;

  spi_master_ctrl #(.DATA_W(DATA_W), .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD)) dut (
    .clk     (clk),
    .rst     (rst),
    .tick    (tick),
    .tx_data (tx_data),
    .tx_valid(tx_valid),
    .tx_last (tx_last),
    .tx_ready(tx_ready),
    .rx_data (rx_data),
    .rx_valid(rx_valid),
    .busy    (busy),
    .sclk    (sclk),
    .mosi    (mosi),
    .miso    (miso),
    .cs_n    (cs_n)
`ifdef SPI_MODE_CFG_EN
    ,
    .cpol    (tb_cpol),
    .cpha    (tb_cpha)
`endif
  );

  always #5 clk = ~clk;

  // Divider stand-in: one-cycle tick every 4 clocks, changed just after posedge.
  initial begin
    forever begin
      repeat (3) begin
        @(posedge clk);
        #1 tick = 1'b0;
      end
      @(posedge clk);
      #1 tick = 1'b1;
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  logic [DATA_W-1:0] sb[$];
  int rx_count = 0, edges = 0, cs_ticks = 0, cs_rises = 0;
  int hold_ticks = 0, tse = 0, ready_bad = 0;
  logic prev_sclk = 1'b0, prev_cs_n = 1'b1;
  logic [DATA_W-1:0] mosi_sh = '0;

  // Monitor: pin activity counters and scoreboard pop on rx_valid.
  initial begin
    logic [DATA_W-1:0] e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (!prev_cs_n && cs_n) begin
          cs_rises++;
          hold_ticks = tse;
        end
        if (!cs_n && tick) cs_ticks++;
        if (sclk != prev_sclk) begin
          edges++;
          tse = 0;
          if (sclk) mosi_sh = {mosi_sh[DATA_W-2:0], mosi};
        end else if (tick) begin
          tse++;
        end
        if ((sclk != tb_cpol) && tx_ready) ready_bad++;
        if (rx_valid) begin
          rx_count++;
          check("rx_expected", 32'(sb.size() != 0), 32'd1);
          if (sb.size() != 0) begin
            e = sb.pop_front();
            check("rx_data", 32'(rx_data), 32'(e));
            check("mosi_bits", 32'(mosi_sh), 32'(e));
          end
        end
      end
      prev_sclk = sclk;
      prev_cs_n = cs_n;
    end
  end

  // Present one word and hold it until accepted; returns on a negedge.
  task automatic send_word(input logic [DATA_W-1:0] d, input logic l);
    int n = 0;
    tx_data  = d;
    tx_last  = l;
    tx_valid = 1'b1;
    while (!tx_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!tx_ready) begin
      check("hs_timeout", 32'(tx_ready), 32'd1);
      tx_valid = 1'b0;
    end else begin
      sb.push_back(d);
      @(posedge clk);
      @(negedge clk);
      tx_valid = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("idle_reached", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int e0, c0, r0, cr0, n;
    rst = 1'b1;
    repeat (4) @(negedge clk);
    check("rst_cs_n", 32'(cs_n), 32'd1);
    check("rst_sclk", 32'(sclk), 32'd0);
    check("rst_mosi", 32'(mosi), 32'd0);
    check("rst_tx_ready", 32'(tx_ready), 32'd0);
    check("rst_rx_valid", 32'(rx_valid), 32'd0);
    check("rst_rx_data", 32'(rx_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", 32'(tx_ready), 32'd1);

    // Single word 0xA5, loopback.
    e0 = edges; c0 = cs_ticks; r0 = rx_count;
    send_word(8'hA5, 1'b1);
    wait_idle();
    check("single_cs_ticks", cs_ticks - c0, CS_SETUP + 2 * DATA_W + CS_HOLD);
    check("single_edges", edges - e0, 2 * DATA_W);
    check("single_rx_cnt", rx_count - r0, 1);
    check("single_hold_ticks", hold_ticks, CS_HOLD);

    // Burst: 0x3C then 0xC3 five ticks into WAIT.
    e0 = edges; c0 = cs_ticks; r0 = rx_count; cr0 = cs_rises;
    send_word(8'h3C, 1'b0);
    n = 0;
    while (!(busy && tx_ready) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("burst_wait_reached", 32'(busy && tx_ready), 32'd1);
    repeat (5) begin
      @(negedge clk);
      while (!tick) @(negedge clk);
    end
    check("wait_sclk_idle", 32'(sclk), 32'd0);
    check("wait_cs_low", 32'(cs_n), 32'd0);
    send_word(8'hC3, 1'b1);
    wait_idle();
    check("burst_cs_ticks", cs_ticks - c0, CS_SETUP + 4 * DATA_W + 5 + CS_HOLD);
    check("burst_edges", edges - e0, 4 * DATA_W);
    check("burst_rx_cnt", rx_count - r0, 2);
    check("burst_cs_rises", cs_rises - cr0, 1);
    check("burst_hold_ticks", hold_ticks, CS_HOLD);

    // Back-pressure: valid held across a three-word burst.
    e0 = edges; r0 = rx_count;
    send_word(8'h11, 1'b0);
    send_word(8'h22, 1'b0);
    send_word(8'h33, 1'b1);
    wait_idle();
    check("bp_rx_cnt", rx_count - r0, 3);
    check("bp_edges", edges - e0, 6 * DATA_W);
    check("ready_low_in_xfer", ready_bad, 0);

    // Reset abort after edge 7 of 0x81, then a clean 0x81.
    e0 = edges; r0 = rx_count;
    send_word(8'h81, 1'b1);
    n = 0;
    while ((edges - e0) < 7 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("abort_at_edge7", edges - e0, 7);
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    check("abort_cs_n", 32'(cs_n), 32'd1);
    check("abort_sclk", 32'(sclk), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    repeat (100) @(negedge clk);
    check("abort_no_rx", rx_count - r0, 0);
    send_word(8'h81, 1'b1);
    wait_idle();
    check("after_abort_rx_cnt", rx_count - r0, 1);

`ifdef SPI_MODE_CFG_EN
    // Mode 3: sclk idles high, sampling on rising (even) edges.
    tb_cpol = 1'b1;
    tb_cpha = 1'b1;
    repeat (3) @(negedge clk);
    check("m3_idle_high", 32'(sclk), 32'd1);
    r0 = rx_count;
    send_word(8'h5A, 1'b1);
    wait_idle();
    check("m3_rx_cnt", rx_count - r0, 1);
    check("m3_idle_after", 32'(sclk), 32'd1);
`endif

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, expected finish before 500000");
    $fatal(1);
  end

endmodule

// File: doc/spi_master_ctrl.md
# spi_master_ctrl

SPI master transaction controller that sequences the SPI serial interface from the one-cycle `tick` pulses of the existing SPI clock divider (`spi_clk_gen`). It accepts words from a host over a valid/ready handshake and drives `cs_n`, `sclk` and `mosi`. It samples `miso` and returns each received word with a one-cycle strobe. Multi-word bursts keep `cs_n` asserted between words.

## Interface
- `DATA_W`, 8: bits per word; MSB first.
- `CS_SETUP`, 1: ticks from `cs_n` falling to the first `sclk` edge; range ≥1.
- `CS_HOLD`, 1: ticks from the last `sclk` edge to `cs_n` rising; range ≥1.

- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `tick`  in  1  half-SPI-period strobe from the divider; one `clk` cycle wide.
- `tx_data`  in  DATA_W  word to transmit.
- `tx_valid`  in  1  `tx_data` is valid.
- `tx_last`  in  1  qualifies `tx_data`; 1 means release `cs_n` after this word.
- `tx_ready`  out  1  controller accepts the word this cycle.
- `rx_data`  out  DATA_W  last received word; held until the next word completes.
- `rx_valid`  out  1  one-cycle strobe; `rx_data` is updated.
- `busy`  out  1  high in every state except IDLE.
- `sclk`  out  1  SPI clock.
- `mosi`  out  1  SPI data out.
- `miso`  in  1  SPI data in.
- `cs_n`  out  1  chip select, active low.

## Operation
- States:
  - IDLE: `tx_ready`=1. On a handshake, latch word and `tx_last`, assert `cs_n`, drive MSB on `mosi`, go to SETUP.
  - SETUP: after CS_SETUP ticks, go to XFER.
  - XFER: each tick toggles `sclk`. There are 2·DATA_W edges per word.
  - After the final edge:
    - If latched last=1, go to HOLD.
    - If latched last=0, go to WAIT.
  - WAIT: `cs_n` stays low, `sclk` idle, `tx_ready`=1. A handshake latches the next word and drives its MSB on `mosi`. The first edge then comes on the next tick in XFER; no SETUP.
  - HOLD: after CS_HOLD ticks, deassert `cs_n`, go to IDLE.
- Mode 0 (CPOL=0, CPHA=0): sample `miso` on odd edges (rising); shift `mosi` on even edges (falling), except after the final edge.
- Handshake:
  - Transfer occurs when `tx_valid && tx_ready`.
  - `tx_ready` is 0 in SETUP, XFER and HOLD.
  - `tx_data` and `tx_last` are ignored unless the handshake occurs.
- `rx_valid` pulses in the `clk` cycle after the tick carrying the final edge. It pulses for every word, including burst words.
- Edge counter width is $clog2(2·DATA_W)+1. It wraps to 0 at the start of each word.
- Reset values: `cs_n`=1, `sclk`=CPOL (0 without the macro), `mosi`=0, `tx_ready`=0 while `rst` is high, `rx_valid`=0, `rx_data`=0, `busy`=0.
- `rst` in any state aborts immediately, with no HOLD phase. No `rx_valid` is produced for the aborted word.
- `tick` in the same cycle as a handshake is not counted. The SETUP count starts on the first tick after entering SETUP.

## Timing
- Outputs `cs_n`, `sclk`, `mosi`, `rx_data`, `rx_valid`, `busy` are registered. `tx_ready` is decoded from the state register and is 1 from the first cycle after `rst` falls.
- `sclk` and `mosi` change in the `clk` cycle after the causing tick.
- `miso` is sampled on the tick cycle of the sampling edge.
- Word duration: 2·DATA_W ticks. Single-word transaction: CS_SETUP + 2·DATA_W + CS_HOLD ticks, plus at most one tick of alignment.

## Configuration
- `SPI_MODE_CFG_EN` defined:
  - Adds ports `cpol` and `cpha` (inputs, 1 bit each), sampled at the IDLE handshake and held for the whole transaction.
  - `sclk` idles at `cpol`.
  - CPHA=1: shift on odd edges; sample on even edges. The MSB is driven on the first edge, not at CS assertion.
  - In WAIT, `sclk` stays at `cpol`.
- Undefined: the ports are absent and mode 0 is fixed.

## Structure
- Package `spi_pkg`: state enum (IDLE, SETUP, XFER, WAIT, HOLD) and the edge-count width function.
- Sub-module `spi_shift_reg`: DATA_W shift register with load, shift-out (MSB) and shift-in (LSB) enables. The controller keeps the FSM and counters.
- `spi_clk_gen` is instantiated beside the controller at the parent level, not inside it.

## Test plan
- Single word, mode 0: `tx_data`=0xA5, `tx_last`=1, `miso` loops from `mosi` -> `mosi` shows 1,0,1,0,0,1,0,1 on rising edges; `rx_data`=0xA5 with one `rx_valid`; `cs_n` low for 1+16+1 ticks.
- Burst: 0x3C (last=0), then 0xC3 (last=1) presented 5 ticks later -> `cs_n` stays low throughout; `sclk` idle during WAIT; two `rx_valid` pulses; `cs_n` rises CS_HOLD ticks after the 32nd edge.
- Back-pressure: `tx_valid` held during XFER -> `tx_ready`=0 until WAIT/IDLE; no word lost or duplicated.
- Reset at edge 7 of word 0x81 -> next cycle `cs_n`=1, `sclk`=0, `busy`=0, no `rx_valid`; a following 0x81 completes normally.
- With `SPI_MODE_CFG_EN`, cpol=1, cpha=1, `miso` driven with 0x5A -> `sclk` idles high; `rx_data`=0x5A sampled on rising (even) edges.
